ads_serial_bus: RTL and testbench

- Two-master, three-slave serial bus subsystem: master front-ends, arbiter with split support, address decoder/mux, three slaves, all in one block.
- Each master issues one fixed transaction per ready pulse. Target and write data are set by parameters; direction comes from the rw input.
- Slave 1 can split a transaction while busy, which frees the bus for the other master.
- Debug state buses expose the arbiter, decoder and slave-1 FSMs.

---
 rtl/ads_serial_bus.sv | 256 +++++++++++++++++++++++++
 tb/tb_ads_serial_bus.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ads_serial_bus.sv
// Two-master / three-slave 1-bit serial bus: request capture, fixed-priority
// arbiter with slave-1 split support, address decoder, slave datapaths.
module ads_serial_bus #(
  parameter logic [1:0] M1_ADDR  = 2'b01,
  parameter logic [1:0] M2_ADDR  = 2'b10,
  parameter logic [7:0] M1_WDATA = 8'hA5,
  parameter logic [7:0] M2_WDATA = 8'h3C,
  parameter logic [7:0] S1_RDATA = 8'h11,
  parameter logic [7:0] S2_RDATA = 8'h22,
  parameter logic [7:0] S3_RDATA = 8'h33
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       m1_ready,
  input  logic       m2_ready,
  input  logic       m1_rw,
  input  logic       m2_rw,
  input  logic       s1_busy,
  output logic [7:0] s1_wdata,
  output logic [7:0] s2_wdata,
  output logic [7:0] s3_wdata,
  output logic [7:0] m1_rdata,
  output logic [7:0] m2_rdata,
  output logic [3:0] arbiter_state,
  output logic [3:0] decoder_state,
  output logic [3:0] slave1_state
);

  typedef enum logic [3:0] {
    ARB_IDLE         = 4'd0,
    ARB_GNT_M1       = 4'd1,
    ARB_GNT_M2       = 4'd2,
    ARB_SPLIT        = 4'd3,
    ARB_SPLIT_GNT_M1 = 4'd4,
    ARB_SPLIT_GNT_M2 = 4'd5
  } arb_t;

  typedef enum logic [3:0] {
    DEC_IDLE  = 4'd0,
    DEC_ADDR  = 4'd1,
    DEC_RW    = 4'd2,
    DEC_WDATA = 4'd3,
    DEC_RDATA = 4'd4,
    DEC_DONE  = 4'd5,
    DEC_ERR   = 4'd6
  } dec_t;

  typedef enum logic [3:0] {
    S1_IDLE  = 4'd0,
    S1_CHECK = 4'd1,
    S1_SPLIT = 4'd2,
    S1_WRITE = 4'd3,
    S1_READ  = 4'd4,
    S1_DONE  = 4'd5
  } s1_t;

  localparam logic [7:0] S_RDATA [3] = '{S1_RDATA, S2_RDATA, S3_RDATA};

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  arb_t arb_q, arb_d;
  dec_t dec_q, dec_d;
  s1_t  s1_q, s1_d;

  logic        m1_req, m2_req;
  logic        split_m1, split_m2;
  logic [2:0]  bit_cnt;
  logic        addr_hi;
  logic [1:0]  route;
  logic [10:0] m1_tx, m2_tx;
  logic [7:0]  m1_rx, m2_rx;
  logic [7:0]  s_rx [3];
  logic [7:0]  s_tx [3];
  logic [7:0]  s_wr [3];

  logic m1_on, m2_on, m1_load, m2_load;
  logic shifting, xfer_end, data_last, split, bus_bit;
  logic m1_eligible, m2_eligible;

  assign m1_on     = (arb_q == ARB_GNT_M1) || (arb_q == ARB_SPLIT_GNT_M1);
  assign m2_on     = (arb_q == ARB_GNT_M2) || (arb_q == ARB_SPLIT_GNT_M2);
  assign m1_load   = ((arb_d == ARB_GNT_M1) || (arb_d == ARB_SPLIT_GNT_M1)) && !m1_on;
  assign m2_load   = ((arb_d == ARB_GNT_M2) || (arb_d == ARB_SPLIT_GNT_M2)) && !m2_on;
  assign shifting  = (dec_q == DEC_ADDR) || (dec_q == DEC_RW) || (dec_q == DEC_WDATA);
  assign xfer_end  = (dec_q == DEC_DONE) || (dec_q == DEC_ERR);
  assign data_last = (bit_cnt == 3'd7);
  assign split     = (s1_q == S1_CHECK) && s1_busy;

  // A master targeting slave 1 must not be granted while a split is outstanding.
  assign m1_eligible = m1_req && !split_m1 && (M1_ADDR != 2'b01);
  assign m2_eligible = m2_req && !split_m2 && (M2_ADDR != 2'b01);

  always_comb begin
    bus_bit = 1'b0;
    if (shifting) begin
      bus_bit = m1_on ? m1_tx[10] : m2_tx[10];
    end else if (dec_q == DEC_RDATA) begin
      case (route)
        2'b01:   bus_bit = s_tx[0][0];
        2'b10:   bus_bit = s_tx[1][0];
        2'b11:   bus_bit = s_tx[2][0];
        default: bus_bit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      arb_q <= ARB_IDLE;
      dec_q <= DEC_IDLE;
      s1_q  <= S1_IDLE;
    end else begin
      arb_q <= arb_d;
      dec_q <= dec_d;
      s1_q  <= s1_d;
    end
  end

  // A pending split owner is re-granted first as soon as slave 1 frees up.
  always_comb begin
    arb_d = arb_q;
    case (arb_q)
      ARB_IDLE: begin
        if (m1_req)      arb_d = ARB_GNT_M1;
        else if (m2_req) arb_d = ARB_GNT_M2;
      end
      ARB_GNT_M1, ARB_GNT_M2: begin
        if (split)         arb_d = ARB_SPLIT;
        else if (xfer_end) arb_d = ARB_IDLE;
      end
      ARB_SPLIT: begin
        if (!s1_busy)                    arb_d = split_m1 ? ARB_GNT_M1 : ARB_GNT_M2;
        else if (split_m1 && m2_eligible) arb_d = ARB_SPLIT_GNT_M2;
        else if (split_m2 && m1_eligible) arb_d = ARB_SPLIT_GNT_M1;
      end
      ARB_SPLIT_GNT_M1, ARB_SPLIT_GNT_M2: begin
        if (xfer_end) arb_d = ARB_SPLIT;
      end
      default: arb_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    dec_d = dec_q;
    case (dec_q)
      DEC_IDLE:  if (m1_on || m2_on) dec_d = DEC_ADDR;
      DEC_ADDR: begin
        if (bit_cnt == 3'd1) dec_d = ({addr_hi, bus_bit} == 2'b00) ? DEC_ERR : DEC_RW;
      end
      DEC_RW: begin
        if (split)        dec_d = DEC_IDLE;
        else if (bus_bit) dec_d = DEC_WDATA;
        else              dec_d = DEC_RDATA;
      end
      DEC_WDATA, DEC_RDATA: if (data_last) dec_d = DEC_DONE;
      DEC_DONE, DEC_ERR:    dec_d = DEC_IDLE;
      default:              dec_d = DEC_IDLE;
    endcase
  end

  always_comb begin
    s1_d = s1_q;
    case (s1_q)
      S1_IDLE: begin
        if (dec_q == DEC_ADDR && dec_d == DEC_RW && {addr_hi, bus_bit} == 2'b01)
          s1_d = S1_CHECK;
      end
      S1_CHECK: begin
        if (s1_busy)      s1_d = S1_SPLIT;
        else if (bus_bit) s1_d = S1_WRITE;
        else              s1_d = S1_READ;
      end
      S1_SPLIT:          if (!s1_busy) s1_d = S1_IDLE;
      S1_WRITE, S1_READ: if (data_last) s1_d = S1_DONE;
      S1_DONE:           s1_d = S1_IDLE;
      default:           s1_d = S1_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      m1_req   <= 1'b0;
      m2_req   <= 1'b0;
      split_m1 <= 1'b0;
      split_m2 <= 1'b0;
    end else begin
      if (m1_on && xfer_end) m1_req <= 1'b0;
      else if (m1_ready)     m1_req <= 1'b1;
      if (m2_on && xfer_end) m2_req <= 1'b0;
      else if (m2_ready)     m2_req <= 1'b1;
      if (split && m1_on)                          split_m1 <= 1'b1;
      else if (arb_q == ARB_SPLIT && !s1_busy)     split_m1 <= 1'b0;
      if (split && m2_on)                          split_m2 <= 1'b1;
      else if (arb_q == ARB_SPLIT && !s1_busy)     split_m2 <= 1'b0;
    end
  end

  // Frames are shifted MSB-first out of an 11-bit register: addr[1:0], rw, data LSB-first.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      bit_cnt  <= 3'd0;
      addr_hi  <= 1'b0;
      route    <= 2'b00;
      m1_tx    <= '0;
      m2_tx    <= '0;
      m1_rx    <= '0;
      m2_rx    <= '0;
      m1_rdata <= '0;
      m2_rdata <= '0;
      for (int i = 0; i < 3; i++) begin
        s_rx[i] <= '0;
        s_tx[i] <= '0;
        s_wr[i] <= '0;
      end
    end else begin
      bit_cnt <= (dec_d != dec_q) ? 3'd0 : bit_cnt + 3'd1;
      if (dec_q == DEC_ADDR && bit_cnt == 3'd0) addr_hi <= bus_bit;
      if (dec_q == DEC_ADDR && bit_cnt == 3'd1) route <= {addr_hi, bus_bit};

      if (m1_load)                m1_tx <= {M1_ADDR, m1_rw, rev8(M1_WDATA)};
      else if (m1_on && shifting) m1_tx <= {m1_tx[9:0], 1'b0};
      if (m2_load)                m2_tx <= {M2_ADDR, m2_rw, rev8(M2_WDATA)};
      else if (m2_on && shifting) m2_tx <= {m2_tx[9:0], 1'b0};

      if (m1_on && dec_q == DEC_RDATA) begin
        m1_rx <= {bus_bit, m1_rx[7:1]};
        if (data_last) m1_rdata <= {bus_bit, m1_rx[7:1]};
      end
      if (m2_on && dec_q == DEC_RDATA) begin
        m2_rx <= {bus_bit, m2_rx[7:1]};
        if (data_last) m2_rdata <= {bus_bit, m2_rx[7:1]};
      end

      for (int i = 0; i < 3; i++) begin
        if (route == 2'(i + 1)) begin
          if (dec_q == DEC_RW && dec_d == DEC_RDATA) s_tx[i] <= S_RDATA[i];
          else if (dec_q == DEC_RDATA)               s_tx[i] <= {1'b0, s_tx[i][7:1]};
          if (dec_q == DEC_WDATA) begin
            s_rx[i] <= {bus_bit, s_rx[i][7:1]};
            if (data_last) s_wr[i] <= {bus_bit, s_rx[i][7:1]};
          end
        end
      end
    end
  end

  assign s1_wdata      = s_wr[0];
  assign s2_wdata      = s_wr[1];
  assign s3_wdata      = s_wr[2];
  assign arbiter_state = arb_q;
  assign decoder_state = dec_q;
  assign slave1_state  = s1_q;

endmodule

// File: tb/tb_ads_serial_bus.sv
// Scoreboard bench for ads_serial_bus: expected bytes queued at stimulus time,
// matched against every observed change of a data output.
module tb_ads_serial_bus;

  localparam logic [1:0] M1_ADDR  = 2'b01;
  localparam logic [1:0] M2_ADDR  = 2'b10;
  localparam logic [7:0] M1_WDATA = 8'hA5;
  localparam logic [7:0] M2_WDATA = 8'h3C;
  localparam logic [7:0] SLV_RDATA [3] = '{8'h11, 8'h22, 8'h33};

  typedef struct {
    int         id;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic m1_ready = 1'b0, m2_ready = 1'b0, m1_rw = 1'b0, m2_rw = 1'b0, s1_busy = 1'b0;
  logic [7:0] s1_wdata, s2_wdata, s3_wdata, m1_rdata, m2_rdata;
  logic [3:0] arbiter_state, decoder_state, slave1_state;

  logic e_m2_ready = 1'b0;
  logic [7:0] e_s1_wdata, e_s2_wdata, e_s3_wdata, e_m1_rdata, e_m2_rdata;
  logic [3:0] e_arb, e_dec, e_s1;

  ads_serial_bus dut (
    .clk(clk), .rstn(rstn),
    .m1_ready(m1_ready), .m2_ready(m2_ready), .m1_rw(m1_rw), .m2_rw(m2_rw), .s1_busy(s1_busy),
    .s1_wdata(s1_wdata), .s2_wdata(s2_wdata), .s3_wdata(s3_wdata),
    .m1_rdata(m1_rdata), .m2_rdata(m2_rdata),
    .arbiter_state(arbiter_state), .decoder_state(decoder_state), .slave1_state(slave1_state)
  );

  // Second instance with master 2 pointed at the unmapped address.
  ads_serial_bus #(.M2_ADDR(2'b00)) u_err (
    .clk(clk), .rstn(rstn),
    .m1_ready(1'b0), .m2_ready(e_m2_ready), .m1_rw(1'b0), .m2_rw(1'b0), .s1_busy(1'b0),
    .s1_wdata(e_s1_wdata), .s2_wdata(e_s2_wdata), .s3_wdata(e_s3_wdata),
    .m1_rdata(e_m1_rdata), .m2_rdata(e_m2_rdata),
    .arbiter_state(e_arb), .decoder_state(e_dec), .slave1_state(e_s1)
  );

  always #5 clk = ~clk;

  string      names [5] = '{"s1_wdata", "s2_wdata", "s3_wdata", "m1_rdata", "m2_rdata"};
  logic [7:0] outs [5];
  logic [7:0] prev [5] = '{default: 8'h00};
  logic [7:0] obs_log [5][32];
  int         obs_cnt [5] = '{default: 0};
  int         rd_ptr [5] = '{default: 0};
  int         matched [5] = '{default: 0};
  int         last_arb [16] = '{default: 0};
  int         last_s1 [16] = '{default: 0};
  int         last_edec [16] = '{default: 0};
  int         cycle = 1;
  int         checks = 0;
  int         errors = 0;
  int         t0;
  exp_t       exp_q [$];

  assign outs[0] = s1_wdata;
  assign outs[1] = s2_wdata;
  assign outs[2] = s3_wdata;
  assign outs[3] = m1_rdata;
  assign outs[4] = m2_rdata;

  // Log every data-output change outside reset, plus the last cycle each state was seen.
  always @(negedge clk) begin
    cycle <= cycle + 1;
    for (int i = 0; i < 5; i++) begin
      prev[i] <= outs[i];
      if (rstn == 1'b0 && outs[i] != prev[i] && obs_cnt[i] < 32) begin
        obs_log[i][obs_cnt[i]] <= outs[i];
        obs_cnt[i] <= obs_cnt[i] + 1;
      end
    end
    last_arb[arbiter_state] <= cycle;
    last_s1[slave1_state]   <= cycle;
    last_edec[e_dec]        <= cycle;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input int master, input logic [1:0] addr, input bit rw);
    exp_t e;
    if (addr == 2'b00) return;
    if (rw) begin
      e.id  = int'(addr) - 1;
      e.val = (master == 1) ? M1_WDATA : M2_WDATA;
    end else begin
      e.id  = 2 + master;
      e.val = SLV_RDATA[int'(addr) - 1];
    end
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit p1, input bit p2, input bit rw1, input bit rw2, input bit score);
    m1_rw    = rw1;
    m2_rw    = rw2;
    m1_ready = p1;
    m2_ready = p2;
    if (score) begin
      if (p1) pushExpect(1, M1_ADDR, rw1);
      if (p2) pushExpect(2, M2_ADDR, rw2);
    end
    @(negedge clk);
    m1_ready = 1'b0;
    m2_ready = 1'b0;
  endtask

  task automatic consumeObs();
    for (int i = 0; i < 5; i++) begin
      while (rd_ptr[i] < obs_cnt[i]) begin
        for (int k = 0; k < exp_q.size(); k++) begin
          if (exp_q[k].id == i) begin
            checkOutput(names[i], obs_log[i][rd_ptr[i]], exp_q[k].val);
            matched[i]++;
            exp_q.delete(k);
            break;
          end
        end
        rd_ptr[i]++;
      end
    end
  endtask

  task automatic waitDrain(input string tag, input int budget, input int leftover);
    int n = 0;
    while (n < budget && exp_q.size() > leftover) begin
      @(negedge clk);
      n++;
      consumeObs();
    end
    repeat (4) @(negedge clk);
    consumeObs();
    checkOutput({tag, "_pending"}, exp_q.size(), leftover);
    for (int i = 0; i < 5; i++) checkOutput({tag, "_extra_", names[i]}, rd_ptr[i], matched[i]);
  endtask

  task automatic waitArb(input logic [3:0] target, input int budget);
    int n = 0;
    while (arbiter_state != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_arb", arbiter_state, target);
  endtask

  task automatic checkIdle(input string tag);
    for (int i = 0; i < 5; i++) checkOutput({tag, "_", names[i]}, outs[i], 8'h00);
    checkOutput({tag, "_arb"}, arbiter_state, 4'd0);
    checkOutput({tag, "_dec"}, decoder_state, 4'd0);
    checkOutput({tag, "_s1"},  slave1_state,  4'd0);
  endtask

  task automatic applyReset();
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    repeat (20) @(negedge clk);
    checkIdle("idle");

    $display("[TB] single write from master 1");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    waitDrain("wr1", 60, 0);
    checkOutput("wr1_arb_idle", arbiter_state, 4'd0);
    checkOutput("wr1_s2_quiet", s2_wdata, 8'h00);
    checkOutput("wr1_s3_quiet", s3_wdata, 8'h00);
    applyReset();

    $display("[TB] simultaneous requests");
    t0 = cycle;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    waitDrain("both", 100, 0);
    checkOutput("both_arb_order", ((last_arb[1] > t0) && (last_arb[2] > last_arb[1])) ? 1 : 0, 1);
    checkOutput("both_arb_idle", arbiter_state, 4'd0);
    applyReset();

    $display("[TB] split on busy slave 1");
    s1_busy = 1'b1;
    t0 = cycle;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    waitDrain("split_a", 100, 1);
    checkOutput("split_s1_held", s1_wdata, 8'h00);
    checkOutput("split_arb_state", arbiter_state, 4'd3);
    checkOutput("split_s1_state", slave1_state, 4'd2);
    checkOutput("split_s1_seen", (last_s1[2] > t0) ? 1 : 0, 1);
    s1_busy = 1'b0;
    waitDrain("split_b", 60, 0);
    checkOutput("split_arb_idle", arbiter_state, 4'd0);
    applyReset();

    $display("[TB] reset during write");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    waitArb(4'd1, 10);
    repeat (6) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkIdle("rst_in");
    rstn = 1'b0;
    repeat (40) @(negedge clk);
    waitDrain("rst_after", 1, 0);
    checkIdle("rst_out");

    $display("[TB] unmapped address");
    for (int pass = 0; pass < 2; pass++) begin
      t0 = cycle;
      e_m2_ready = 1'b1;
      @(negedge clk);
      e_m2_ready = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("err_dec_seen", (last_edec[6] > t0) ? 1 : 0, 1);
      checkOutput("err_arb_idle", e_arb, 4'd0);
      checkOutput("err_dec_idle", e_dec, 4'd0);
      checkOutput("err_outputs", {e_s1_wdata, e_s2_wdata, e_s3_wdata, e_m2_rdata}, 32'h0);
      checkOutput("err_m1_rdata", e_m1_rdata, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
